// File: rtl/mem_wb_stage_if.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_if
// Bundles the E/M pipeline-register outputs that enter the memory stage and
// the M/W pipeline-register outputs that leave it.
//   master : drives the M-stage inputs, observes the M/W outputs
//   slave  : the memory stage itself (mem_wb_stage)
// Signals:
//   Instr_M_I, PC_M_I, ALURS_M_I, WD_M_I, Dst_M_I, Tnew_M_I   (into the stage)
//   Instr_MW_O, PC_MW_O, WBData_MW_O, Dst_MW_O, Tnew_MW_O,
//   AdErr_MW_O                                               (registered out)
//   MRD_M_O                                                  (combinational out)
// -----------------------------------------------------------------------------
interface mem_wb_stage_if;
   logic [31:0] Instr_M_I;
   logic [31:0] PC_M_I;
   logic [31:0] ALURS_M_I;
   logic [31:0] WD_M_I;
   logic [4:0]  Dst_M_I;
   logic [2:0]  Tnew_M_I;

   logic [31:0] Instr_MW_O;
   logic [31:0] PC_MW_O;
   logic [31:0] WBData_MW_O;
   logic [4:0]  Dst_MW_O;
   logic [2:0]  Tnew_MW_O;
   logic [1:0]  AdErr_MW_O;
   logic [31:0] MRD_M_O;

   modport master (
      output Instr_M_I, PC_M_I, ALURS_M_I, WD_M_I, Dst_M_I, Tnew_M_I,
      input  Instr_MW_O, PC_MW_O, WBData_MW_O, Dst_MW_O, Tnew_MW_O,
             AdErr_MW_O, MRD_M_O
   );

   modport slave (
      input  Instr_M_I, PC_M_I, ALURS_M_I, WD_M_I, Dst_M_I, Tnew_M_I,
      output Instr_MW_O, PC_MW_O, WBData_MW_O, Dst_MW_O, Tnew_MW_O,
             AdErr_MW_O, MRD_M_O
   );
endinterface

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Memory stage of the 5-stage MIPS pipeline plus the M/W pipeline register.
// Holds the data memory, performs lw/lh/lhu/lb/lbu and sw/sh/sb with range
// and alignment checking, and performs the M->W Tnew countdown.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; clears M/W register and memory
//   bus    mem_wb_stage_if.slave (M-stage inputs, M/W outputs, MRD_M_O)
// Optional build macro:
//   DM_WRITE_LOG_EN  when defined, each legal store prints
//                    "@<pc>: *<word address> <= <resulting word>" in simulation.
// -----------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int          DM_WORDS = 1024,
   parameter int          DM_AW    = 10,
   parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
   input  logic           clk,
   input  logic           reset,
   mem_wb_stage_if.slave  bus
);

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   // ---------------------------------------------------------------- decode
   logic [31:0]      addr;
   logic [DM_AW-1:0] word_idx;
   logic             is_load;
   logic             is_store;
   logic             sign_ext;
   size_t            acc_size;
   logic             in_range;
   logic             aligned;
   logic             legal;

   assign addr     = bus.ALURS_M_I;
   assign word_idx = addr[DM_AW+1:2];
   assign in_range = (addr[31:DM_AW+2] == '0);

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      sign_ext = 1'b0;
      acc_size = SZ_WORD;
      case (bus.Instr_M_I[31:26])
         OP_LW:  begin is_load  = 1'b1; acc_size = SZ_WORD; end
         OP_LH:  begin is_load  = 1'b1; acc_size = SZ_HALF; sign_ext = 1'b1; end
         OP_LHU: begin is_load  = 1'b1; acc_size = SZ_HALF; end
         OP_LB:  begin is_load  = 1'b1; acc_size = SZ_BYTE; sign_ext = 1'b1; end
         OP_LBU: begin is_load  = 1'b1; acc_size = SZ_BYTE; end
         OP_SW:  begin is_store = 1'b1; acc_size = SZ_WORD; end
         OP_SH:  begin is_store = 1'b1; acc_size = SZ_HALF; end
         OP_SB:  begin is_store = 1'b1; acc_size = SZ_BYTE; end
         default: ;
      endcase
   end

   always_comb begin
      case (acc_size)
         SZ_WORD: aligned = (addr[1:0] == 2'b00);
         SZ_HALF: aligned = (addr[0] == 1'b0);
         default: aligned = 1'b1;
      endcase
   end

   assign legal = in_range && aligned;

   // ---------------------------------------------------------------- memory
   logic [31:0] mem [DM_WORDS];
   logic [31:0] rd_word;

   // Read is asynchronous so the loaded value is available in the same
   // cycle for MRD_M_O and the M/W write-back mux.
   assign rd_word = mem[word_idx];

   // ---------------------------------------------------------------- load path
   logic [15:0] ld_half;
   logic [7:0]  ld_byte;
   logic [31:0] ld_ext;

   always_comb begin
      ld_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (addr[1:0])
         2'd0:    ld_byte = rd_word[7:0];
         2'd1:    ld_byte = rd_word[15:8];
         2'd2:    ld_byte = rd_word[23:16];
         default: ld_byte = rd_word[31:24];
      endcase
      case (acc_size)
         SZ_WORD: ld_ext = rd_word;
         SZ_HALF: ld_ext = {{16{sign_ext & ld_half[15]}}, ld_half};
         default: ld_ext = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      endcase
   end

   assign bus.MRD_M_O = (is_load && legal) ? ld_ext : 32'h0;

   // ---------------------------------------------------------------- store path
   logic [3:0]  byte_en;
   logic [31:0] wr_lanes;
   logic [31:0] merged_word;
   logic        mem_we;

   always_comb begin
      case (acc_size)
         SZ_WORD: begin
            byte_en  = 4'b1111;
            wr_lanes = bus.WD_M_I;
         end
         SZ_HALF: begin
            byte_en  = addr[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{bus.WD_M_I[15:0]}};
         end
         default: begin
            byte_en  = 4'b0001 << addr[1:0];
            wr_lanes = {4{bus.WD_M_I[7:0]}};
         end
      endcase
   end

   // Read-modify-write merge: unselected bytes keep their current contents.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign merged_word[gi*8 +: 8] = byte_en[gi] ? wr_lanes[gi*8 +: 8]
                                                     : rd_word[gi*8 +: 8];
      end
   endgenerate

   assign mem_we = is_store && legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DM_WORDS; i++) begin
            mem[i] <= 32'h0;
         end
      end else if (mem_we) begin
         mem[word_idx] <= merged_word;
      end
   end

`ifdef DM_WRITE_LOG_EN
   always_ff @(posedge clk) begin
      if (!reset && mem_we) begin
         $display("@%h: *%h <= %h", bus.PC_M_I, {addr[31:2], 2'b00}, merged_word);
      end
   end
`endif

   // ---------------------------------------------------------------- M/W register
   logic [31:0] instr_reg, pc_reg, wb_data_reg;
   logic [4:0]  dst_reg;
   logic [2:0]  tnew_reg;
   logic [1:0]  aderr_reg;

   logic [31:0] wb_data_next;
   logic [2:0]  tnew_next;
   logic [1:0]  aderr_next;

   assign wb_data_next = is_load ? bus.MRD_M_O : bus.ALURS_M_I;
   // Saturating countdown: a result already available stays available.
   assign tnew_next    = (bus.Tnew_M_I != 3'd0) ? bus.Tnew_M_I - 3'd1 : 3'd0;
   assign aderr_next   = {is_store && !legal, is_load && !legal};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_reg   <= 32'h0;
         pc_reg      <= PC_RESET;
         wb_data_reg <= 32'h0;
         dst_reg     <= 5'd0;
         tnew_reg    <= 3'd0;
         aderr_reg   <= 2'b00;
      end else begin
         instr_reg   <= bus.Instr_M_I;
         pc_reg      <= bus.PC_M_I;
         wb_data_reg <= wb_data_next;
         dst_reg     <= bus.Dst_M_I;
         tnew_reg    <= tnew_next;
         aderr_reg   <= aderr_next;
      end
   end

   assign bus.Instr_MW_O  = instr_reg;
   assign bus.PC_MW_O     = pc_reg;
   assign bus.WBData_MW_O = wb_data_reg;
   assign bus.Dst_MW_O    = dst_reg;
   assign bus.Tnew_MW_O   = tnew_reg;
   assign bus.AdErr_MW_O  = aderr_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed, table-driven bench for mem_wb_stage plus hand-written sequences
// for asynchronous reset (mid-cycle and coinciding with a store edge).
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

   localparam logic [31:0] I_LW   = 32'h8C00_0000;
   localparam logic [31:0] I_LH   = 32'h8400_0000;
   localparam logic [31:0] I_LHU  = 32'h9400_0000;
   localparam logic [31:0] I_LB   = 32'h8000_0000;
   localparam logic [31:0] I_LBU  = 32'h9000_0000;
   localparam logic [31:0] I_SW   = 32'hAC00_0000;
   localparam logic [31:0] I_SH   = 32'hA400_0000;
   localparam logic [31:0] I_SB   = 32'hA000_0000;
   localparam logic [31:0] I_ADDU = 32'h0000_2821;   // addu $5, $0, $0

   typedef struct {
      logic [31:0] instr;
      logic [31:0] alurs;
      logic [31:0] wd;
      logic [4:0]  dst;
      logic [2:0]  tnew;
      logic [31:0] exp_mrd;
      logic [31:0] exp_wb;
      logic [2:0]  exp_tnew;
      logic [1:0]  exp_aderr;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mem_wb_stage_if bus ();

   mem_wb_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " instr"}, bus.Instr_MW_O, 32'h0);
      chk({tag, " pc"},    bus.PC_MW_O, 32'h0000_3000);
      chk({tag, " wb"},    bus.WBData_MW_O, 32'h0);
      chk({tag, " dst"},   {27'h0, bus.Dst_MW_O}, 32'h0);
      chk({tag, " tnew"},  {29'h0, bus.Tnew_MW_O}, 32'h0);
      chk({tag, " aderr"}, {30'h0, bus.AdErr_MW_O}, 32'h0);
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] dst, input logic [2:0] tnew);
      bus.Instr_M_I = instr;
      bus.PC_M_I    = pc;
      bus.ALURS_M_I = a;
      bus.WD_M_I    = wd;
      bus.Dst_M_I   = dst;
      bus.Tnew_M_I  = tnew;
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [4:0] dst,
                               input logic [2:0] tnew, input logic [31:0] mrd,
                               input logic [31:0] wb, input logic [2:0] etnew,
                               input logic [1:0] aderr);
      vec_t v;
      v.instr = instr; v.alurs = a; v.wd = wd; v.dst = dst; v.tnew = tnew;
      v.exp_mrd = mrd; v.exp_wb = wb; v.exp_tnew = etnew; v.exp_aderr = aderr;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      logic [31:0] pc;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0);

      //          instr   A             WD            dst  tn  exp_mrd       exp_wb        tn  aderr
      vecs.push_back(mk(I_SW,  32'h10,   32'hDEADBEEF, 0, 1, 32'h0,        32'h10,       0, 2'b00));
      vecs.push_back(mk(I_LW,  32'h10,   32'h0,        8, 3, 32'hDEADBEEF, 32'hDEADBEEF, 2, 2'b00));
      vecs.push_back(mk(I_SW,  32'h10,   32'h11223344, 0, 1, 32'h0,        32'h10,       0, 2'b00));
      vecs.push_back(mk(I_SB,  32'h13,   32'h555555AA, 0, 0, 32'h0,        32'h13,       0, 2'b00));
      vecs.push_back(mk(I_LW,  32'h10,   32'h0,        9, 1, 32'hAA223344, 32'hAA223344, 0, 2'b00));
      vecs.push_back(mk(I_LB,  32'h13,   32'h0,        9, 1, 32'hFFFFFFAA, 32'hFFFFFFAA, 0, 2'b00));
      vecs.push_back(mk(I_LBU, 32'h13,   32'h0,        9, 1, 32'h000000AA, 32'h000000AA, 0, 2'b00));
      vecs.push_back(mk(I_LB,  32'h12,   32'h0,        9, 1, 32'h00000022, 32'h00000022, 0, 2'b00));
      vecs.push_back(mk(I_SH,  32'h1A,   32'hCCCC8001, 0, 0, 32'h0,        32'h1A,       0, 2'b00));
      vecs.push_back(mk(I_LW,  32'h18,   32'h0,        4, 1, 32'h80010000, 32'h80010000, 0, 2'b00));
      vecs.push_back(mk(I_LH,  32'h1A,   32'h0,        4, 1, 32'hFFFF8001, 32'hFFFF8001, 0, 2'b00));
      vecs.push_back(mk(I_LHU, 32'h18,   32'h0,        4, 1, 32'h00000000, 32'h00000000, 0, 2'b00));
      vecs.push_back(mk(I_LHU, 32'h1A,   32'h0,        4, 1, 32'h00008001, 32'h00008001, 0, 2'b00));
      vecs.push_back(mk(I_LH,  32'h10,   32'h0,        4, 1, 32'h00003344, 32'h00003344, 0, 2'b00));
      vecs.push_back(mk(I_SW,  32'h11,   32'hFFFFFFFF, 0, 0, 32'h0,        32'h11,       0, 2'b10));
      vecs.push_back(mk(I_SH,  32'h13,   32'hFFFFFFFF, 0, 0, 32'h0,        32'h13,       0, 2'b10));
      vecs.push_back(mk(I_LW,  32'h10,   32'h0,        6, 1, 32'hAA223344, 32'hAA223344, 0, 2'b00));
      vecs.push_back(mk(I_LH,  32'h13,   32'h0,        6, 1, 32'h0,        32'h0,        0, 2'b01));
      vecs.push_back(mk(I_LW,  32'h12,   32'h0,        6, 1, 32'h0,        32'h0,        0, 2'b01));
      vecs.push_back(mk(I_LW,  32'h1000, 32'h0,        6, 1, 32'h0,        32'h0,        0, 2'b01));
      vecs.push_back(mk(I_SW,  32'h1000, 32'h77777777, 0, 0, 32'h0,        32'h1000,     0, 2'b10));
      vecs.push_back(mk(I_LW,  32'h0,    32'h0,        7, 1, 32'h0,        32'h0,        0, 2'b00));
      vecs.push_back(mk(I_SB,  32'hFFF,  32'h0000005A, 0, 0, 32'h0,        32'hFFF,      0, 2'b00));
      vecs.push_back(mk(I_LBU, 32'hFFF,  32'h0,        7, 1, 32'h0000005A, 32'h0000005A, 0, 2'b00));
      vecs.push_back(mk(I_LW,  32'hFFC,  32'h0,        7, 1, 32'h5A000000, 32'h5A000000, 0, 2'b00));
      vecs.push_back(mk(I_ADDU,32'h1234, 32'h0,        5, 2, 32'h0,        32'h1234,     1, 2'b00));
      vecs.push_back(mk(I_ADDU,32'h1234, 32'h0,        5, 0, 32'h0,        32'h1234,     0, 2'b00));
      vecs.push_back(mk(I_ADDU,32'hFFFFFFFF, 32'h0,    5, 7, 32'h0,        32'hFFFFFFFF, 6, 2'b00));
      vecs.push_back(mk(32'h0, 32'h0,    32'h0,        0, 0, 32'h0,        32'h0,        0, 2'b00));

      // Reset state, observed while reset is still held.
      #1;
      chk_reset_state("por");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // ---------------------------------------------------- table-driven vectors
      pc = 32'h0000_3000;
      for (int i = 0; i < vecs.size(); i++) begin
         if (i != 0) @(negedge clk);
         drive(vecs[i].instr, pc, vecs[i].alurs, vecs[i].wd, vecs[i].dst, vecs[i].tnew);
         #1;
         chk($sformatf("v%0d mrd", i), bus.MRD_M_O, vecs[i].exp_mrd);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d instr", i), bus.Instr_MW_O, vecs[i].instr);
         chk($sformatf("v%0d pc", i),    bus.PC_MW_O, pc);
         chk($sformatf("v%0d wb", i),    bus.WBData_MW_O, vecs[i].exp_wb);
         chk($sformatf("v%0d dst", i),   {27'h0, bus.Dst_MW_O}, {27'h0, vecs[i].dst});
         chk($sformatf("v%0d tnew", i),  {29'h0, bus.Tnew_MW_O}, {29'h0, vecs[i].exp_tnew});
         chk($sformatf("v%0d aderr", i), {30'h0, bus.AdErr_MW_O}, {30'h0, vecs[i].exp_aderr});
         $display("vec %0d: instr=%h A=%h wd=%h -> wb=%h mrd=%h tnew=%0d aderr=%b",
                  i, vecs[i].instr, vecs[i].alurs, vecs[i].wd, bus.WBData_MW_O,
                  vecs[i].exp_mrd, bus.Tnew_MW_O, bus.AdErr_MW_O);
         pc = pc + 32'd4;
      end

      // ---------------------------------------------------- async reset mid-cycle
      @(negedge clk);
      drive(I_LW, 32'h0000_4000, 32'h10, 32'h0, 5'd3, 3'd2);
      @(posedge clk);
      #1;
      chk("pre-rst wb", bus.WBData_MW_O, 32'hAA223344);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_state("async");
      chk("async mrd cleared", bus.MRD_M_O, 32'h0);
      $display("seq async-reset: pc=%h wb=%h mrd=%h", bus.PC_MW_O, bus.WBData_MW_O, bus.MRD_M_O);

      // ---------------------------------------------------- store during reset edge
      @(negedge clk);
      drive(I_SW, 32'h0000_4004, 32'h20, 32'h00000055, 5'd0, 3'd0);
      @(posedge clk);
      #1;
      chk_reset_state("rst-edge");
      @(negedge clk);
      reset = 1'b0;
      drive(I_LW, 32'h0000_4008, 32'h20, 32'h0, 5'd2, 3'd1);
      #1;
      chk("rst-store mrd", bus.MRD_M_O, 32'h0);
      @(posedge clk);
      #1;
      chk("rst-store wb", bus.WBData_MW_O, 32'h0);
      chk("rst-store instr", bus.Instr_MW_O, I_LW);
      $display("seq reset-store: lw 0x20 wb=%h", bus.WBData_MW_O);

      @(negedge clk);
      drive(I_LW, 32'h0000_400C, 32'h10, 32'h0, 5'd2, 3'd1);
      @(posedge clk);
      #1;
      chk("cleared 0x10 wb", bus.WBData_MW_O, 32'h0);
      chk("cleared 0x10 aderr", {30'h0, bus.AdErr_MW_O}, 32'h0);
      $display("seq post-reset: lw 0x10 wb=%h", bus.WBData_MW_O);

      // ---------------------------------------------------- store/load after reset
      @(negedge clk);
      drive(I_SW, 32'h0000_4010, 32'h24, 32'hCAFEF00D, 5'd0, 3'd0);
      @(negedge clk);
      drive(I_LW, 32'h0000_4014, 32'h24, 32'h0, 5'd2, 3'd1);
      @(posedge clk);
      #1;
      chk("post-rst lw wb", bus.WBData_MW_O, 32'hCAFEF00D);
      chk("post-rst lw pc", bus.PC_MW_O, 32'h0000_4014);
      $display("seq store-load: lw 0x24 wb=%h", bus.WBData_MW_O);

      @(negedge clk);
      drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
